ps2_keyboard_rx: RTL and testbench



---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_line_filter.sv | 41 ++++
 rtl/ps2_keyboard_rx.sv | 166 ++++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types, constants and helpers for the PS/2 keyboard receiver.
package ps2_pkg;

  localparam int unsigned PS2_FILTER_DEF  = 8;
  localparam int unsigned PS2_TIMEOUT_DEF = 11200;
  localparam int unsigned PS2_TCNT_W      = 14;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_t;

  // Keyboard status/response bytes that never reach the key matrix.
  function automatic logic ps2_drop(input logic [7:0] b);
    case (b)
      8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF, 8'hE1: ps2_drop = 1'b1;
      default:                                                ps2_drop = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// 2-FF synchroniser, saturating glitch filter and falling-edge pulse for one PS/2 line.
module ps2_line_filter #(
  parameter int unsigned FILTER = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic pin,
  output logic line,
  output logic fall
);

  localparam int unsigned CW = $clog2(FILTER + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          line_q;

  // Filtered line flips only after FILTER consecutive samples disagree with it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync   <= 2'b11;
      cnt    <= '0;
      line   <= 1'b1;
      line_q <= 1'b1;
      fall   <= 1'b0;
    end else begin
      sync   <= {sync[0], pin};
      line_q <= line;
      fall   <= line_q & ~line;
      if (sync[1] == line) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER - 1)) begin
        line <= sync[1];
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: deframes device-to-host frames, strips F0/E0 prefixes
// and emits one strobed scan-code event per key transition.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER  = PS2_FILTER_DEF,
  parameter int unsigned TIMEOUT = PS2_TIMEOUT_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2ck,
  input  logic       ps2d,
  output logic       kstb,
  output logic       make,
  output logic [7:0] code,
  output logic       ext,
  output logic       err
);

  localparam logic [PS2_TCNT_W-1:0] TCNT_MAX = '1;

  logic ck_fall;
  logic ck_line_unused;
  logic d_line;
  logic d_fall_unused;

  ps2_line_filter #(.FILTER(FILTER)) u_ck_filter (
    .clock (clock),
    .reset (reset),
    .pin   (ps2ck),
    .line  (ck_line_unused),
    .fall  (ck_fall)
  );

  ps2_line_filter #(.FILTER(FILTER)) u_d_filter (
    .clock (clock),
    .reset (reset),
    .pin   (ps2d),
    .line  (d_line),
    .fall  (d_fall_unused)
  );

  ps2_state_t            state, state_n;
  logic [2:0]            bitcnt, bitcnt_n;
  logic [7:0]            shreg, shreg_n;
  logic                  par, par_n;
  logic                  brk, brk_n;
  logic                  extf, extf_n;
  logic [PS2_TCNT_W-1:0] tcnt, tcnt_n;
  logic                  kstb_n, make_n, ext_n, err_n;
  logic [7:0]            code_n;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      bitcnt <= '0;
      shreg  <= '0;
      par    <= 1'b0;
      brk    <= 1'b0;
      extf   <= 1'b0;
      tcnt   <= '0;
      kstb   <= 1'b0;
      make   <= 1'b0;
      code   <= '0;
      ext    <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      bitcnt <= bitcnt_n;
      shreg  <= shreg_n;
      par    <= par_n;
      brk    <= brk_n;
      extf   <= extf_n;
      tcnt   <= tcnt_n;
      kstb   <= kstb_n;
      make   <= make_n;
      code   <= code_n;
      ext    <= ext_n;
      err    <= err_n;
    end
  end

  always_comb begin
    state_n  = state;
    bitcnt_n = bitcnt;
    shreg_n  = shreg;
    par_n    = par;
    brk_n    = brk;
    extf_n   = extf;
    kstb_n   = 1'b0;
    err_n    = 1'b0;
    make_n   = make;
    code_n   = code;
    ext_n    = ext;

    // Bit-gap counter: parked in IDLE, cleared by every accepted clock edge.
    if (state == ST_IDLE || ck_fall) begin
      tcnt_n = '0;
    end else if (tcnt == TCNT_MAX) begin
      tcnt_n = tcnt;
    end else begin
      tcnt_n = tcnt + PS2_TCNT_W'(1);
    end

    case (state)
      ST_IDLE: begin
        if (ck_fall && !d_line) begin
          state_n  = ST_DATA;
          bitcnt_n = '0;
        end
      end
      ST_DATA: begin
        if (ck_fall) begin
          shreg_n  = {d_line, shreg[7:1]};
          bitcnt_n = bitcnt + 3'(1);
          if (bitcnt == 3'd7) begin
            state_n = ST_PARITY;
          end
        end
      end
      ST_PARITY: begin
        if (ck_fall) begin
          par_n   = d_line;
          state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        if (ck_fall) begin
          state_n = ST_IDLE;
          if (d_line && ((^shreg) ^ par)) begin
            if (shreg == PS2_BREAK) begin
              brk_n = 1'b1;
            end else if (shreg == PS2_EXT) begin
              extf_n = 1'b1;
            end else if (ps2_drop(shreg)) begin
              brk_n  = 1'b0;
              extf_n = 1'b0;
            end else begin
              kstb_n = 1'b1;
              code_n = shreg;
              make_n = ~brk;
              ext_n  = extf;
              brk_n  = 1'b0;
              extf_n = 1'b0;
            end
          end else begin
            err_n  = 1'b1;
            brk_n  = 1'b0;
            extf_n = 1'b0;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // A clock edge in the expiry cycle takes priority over the timeout.
    if (state != ST_IDLE && !ck_fall && tcnt >= PS2_TCNT_W'(TIMEOUT)) begin
      err_n   = 1'b1;
      state_n = ST_IDLE;
      brk_n   = 1'b0;
      extf_n  = 1'b0;
      tcnt_n  = '0;
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboard bench for ps2_keyboard_rx: directed PS/2 frames, decoupled event monitor.
`timescale 1ns/1ps
module tb_ps2_keyboard_rx;

  localparam int unsigned FILTER  = 8;
  localparam int unsigned TIMEOUT = 400;
  localparam int unsigned HALF    = 40;

  logic       clock = 1'b0;
  logic       reset;
  logic       ps2ck;
  logic       ps2d;
  logic       kstb;
  logic       make;
  logic [7:0] code;
  logic       ext;
  logic       err;

  typedef struct packed {
    logic       is_err;
    logic [7:0] code;
    logic       make;
    logic       ext;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  ps2_keyboard_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .clock (clock),
    .reset (reset),
    .ps2ck (ps2ck),
    .ps2d  (ps2d),
    .kstb  (kstb),
    .make  (make),
    .code  (code),
    .ext   (ext),
    .err   (err)
  );

  always #5 clock = ~clock;

  task automatic clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic exp_key(input logic [7:0] c, input logic m, input logic e);
    exp_t x;
    x.is_err = 1'b0;
    x.code   = c;
    x.make   = m;
    x.ext    = e;
    q.push_back(x);
  endtask

  task automatic exp_err();
    exp_t x;
    x = '0;
    x.is_err = 1'b1;
    q.push_back(x);
  endtask

  // Sends the first nbits of a frame (start, 8 data LSB first, odd parity, stop).
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2d = f[i];
      clk(HALF);
      ps2ck = 1'b0;
      clk(HALF);
      ps2ck = 1'b1;
    end
    ps2d = 1'b1;
    clk(2 * HALF);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Monitor: every strobe pops one expectation.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && (kstb || err)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got kstb=%0b err=%0b code=%h make=%0b ext=%0b want none",
                 kstb, err, code, make, ext);
      end else begin
        e = q.pop_front();
        if ((kstb && err) || (err !== e.is_err) ||
            (kstb && (code !== e.code || make !== e.make || ext !== e.ext))) begin
          errors++;
          $display("FAIL event: got kstb=%0b err=%0b code=%h make=%0b ext=%0b want err=%0b code=%h make=%0b ext=%0b",
                   kstb, err, code, make, ext, e.is_err, e.code, e.make, e.ext);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    ps2ck = 1'b1;
    ps2d  = 1'b1;
    clk(3);
    chk("rst_kstb", 8'(kstb), 8'h00);
    chk("rst_make", 8'(make), 8'h00);
    chk("rst_code", code,     8'h00);
    chk("rst_ext",  8'(ext),  8'h00);
    chk("rst_err",  8'(err),  8'h00);
    reset = 1'b0;
    clk(20);

    // Plain make code
    exp_key(8'h1C, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 11);

    // Break code
    send_frame(8'hF0, 1'b0, 11);
    exp_key(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 11);

    // Extended break followed by a plain make
    send_frame(8'hE0, 1'b0, 11);
    send_frame(8'hF0, 1'b0, 11);
    exp_key(8'h75, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 11);
    exp_key(8'h75, 1'b1, 1'b0);
    send_frame(8'h75, 1'b0, 11);

    // Parity error then recovery
    exp_err();
    send_frame(8'h1C, 1'b1, 11);
    exp_key(8'h2A, 1'b1, 1'b0);
    send_frame(8'h2A, 1'b0, 11);

    // Partial frame abandoned by timeout, then recovery
    exp_err();
    send_frame(8'h1C, 1'b0, 5);
    clk(TIMEOUT + 100);
    exp_key(8'h1C, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 11);

    // Short clock glitches must be ignored
    for (int g = 0; g < 4; g++) begin
      ps2ck = 1'b0;
      clk(3);
      ps2ck = 1'b1;
      clk(20);
    end

    // Reset mid-frame after a break prefix discards everything
    send_frame(8'hF0, 1'b0, 11);
    send_frame(8'h1C, 1'b0, 4);
    reset = 1'b1;
    clk(3);
    reset = 1'b0;
    clk(50);
    exp_key(8'h1C, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 11);

    clk(200);
    chk("held_code", code,     8'h1C);
    chk("held_make", 8'(make), 8'h01);
    chk("held_ext",  8'(ext),  8'h00);
    chk("pending",   8'(q.size()), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
